// File: rtl/jacobi_iter_sequencer.sv
// Phase sequencer for one Jacobi solve: LOAD_Y -> ACCUM -> WRITE_V -> SWAP per iteration, with a per-phase watchdog.
// Optional early exit on convergence is enabled by defining JACOBI_CONV_EXIT_EN.
module jacobi_iter_sequencer #(
    parameter int NUM_ITERS = 20,
    parameter int ITER_W    = 8,
    parameter int TIMEOUT_W = 12
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              y_load_done,
    input  logic              accum_done,
    input  logic              vwrite_done,
    input  logic              conv_flag,
    output logic              y_load_en,
    output logic              accum_en,
    output logic              vwrite_en,
    output logic              vsram_rd_bank,
    output logic              vsram_wr_bank,
    output logic [ITER_W-1:0] iter_count,
    output logic              busy,
    output logic              all_iters_done,
    output logic              timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD_Y  = 3'd1,
        ST_ACCUM   = 3'd2,
        ST_WRITE_V = 3'd3,
        ST_SWAP    = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERROR   = 3'd6
    } state_t;

    localparam logic [TIMEOUT_W-1:0] WD_ZERO = {TIMEOUT_W{1'b0}};
    localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
    // Last count before all-ones: the step that would reach all-ones is the timeout.
    localparam logic [TIMEOUT_W-1:0] WD_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};
    localparam logic [ITER_W-1:0]    ITER_ZERO = {ITER_W{1'b0}};
    localparam logic [ITER_W-1:0]    ITER_ONE  = {{(ITER_W-1){1'b0}}, 1'b1};
    localparam logic [ITER_W-1:0]    ITER_LAST = ITER_W'(NUM_ITERS - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [TIMEOUT_W-1:0] wd_r;
    logic                wd_timeout_s;
    logic                phase_s;
    logic                start_ok_s;
    logic                last_iter_s;

    logic                y_load_en_nxt_s;
    logic                accum_en_nxt_s;
    logic                vwrite_en_nxt_s;
    logic                rd_bank_nxt_s;
    logic [ITER_W-1:0]   iter_nxt_s;
    logic                busy_nxt_s;
    logic                done_pulse_nxt_s;
    logic                terr_nxt_s;

    logic                y_load_en_r;
    logic                accum_en_r;
    logic                vwrite_en_r;
    logic                rd_bank_r;
    logic                wr_bank_r;
    logic [ITER_W-1:0]   iter_count_r;
    logic                busy_r;
    logic                done_pulse_r;
    logic                terr_r;

    assign phase_s      = (state_r == ST_LOAD_Y) || (state_r == ST_ACCUM) || (state_r == ST_WRITE_V);
    assign wd_timeout_s = (wd_r == WD_LAST);
    assign start_ok_s   = start && ((state_r == ST_IDLE) || (state_r == ST_DONE) || (state_r == ST_ERROR));

`ifdef JACOBI_CONV_EXIT_EN
    assign last_iter_s = (iter_count_r == ITER_LAST) || conv_flag;
`else
    logic unused_conv_s;
    assign unused_conv_s = conv_flag;
    assign last_iter_s   = (iter_count_r == ITER_LAST);
`endif

    // State register and phase watchdog
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            wd_r    <= WD_ZERO;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s != state_r) begin
                wd_r <= WD_ZERO;
            end else if (phase_s) begin
                wd_r <= wd_r + WD_ONE;
            end else begin
                wd_r <= wd_r;
            end
        end
    end

    // Next-state logic; each done is honoured only in its own phase
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) state_nxt_s = ST_LOAD_Y;
                else       state_nxt_s = state_r;
            end
            ST_LOAD_Y: begin
                if (y_load_done)       state_nxt_s = ST_ACCUM;
                else if (wd_timeout_s) state_nxt_s = ST_ERROR;
                else                   state_nxt_s = ST_LOAD_Y;
            end
            ST_ACCUM: begin
                if (accum_done)        state_nxt_s = ST_WRITE_V;
                else if (wd_timeout_s) state_nxt_s = ST_ERROR;
                else                   state_nxt_s = ST_ACCUM;
            end
            ST_WRITE_V: begin
                if (vwrite_done)       state_nxt_s = ST_SWAP;
                else if (wd_timeout_s) state_nxt_s = ST_ERROR;
                else                   state_nxt_s = ST_WRITE_V;
            end
            ST_SWAP: begin
                if (last_iter_s) state_nxt_s = ST_DONE;
                else             state_nxt_s = ST_LOAD_Y;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Output next-values, derived from the upcoming state so enables track state entry
    always_comb begin
        y_load_en_nxt_s  = (state_nxt_s == ST_LOAD_Y);
        accum_en_nxt_s   = (state_nxt_s == ST_ACCUM);
        vwrite_en_nxt_s  = (state_nxt_s == ST_WRITE_V);
        busy_nxt_s       = (state_nxt_s != ST_IDLE) && (state_nxt_s != ST_DONE) && (state_nxt_s != ST_ERROR);
        done_pulse_nxt_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
        rd_bank_nxt_s    = rd_bank_r;
        iter_nxt_s       = iter_count_r;
        terr_nxt_s       = terr_r;
        if (state_r == ST_SWAP) begin
            rd_bank_nxt_s = ~rd_bank_r;
            iter_nxt_s    = iter_count_r + ITER_ONE;
        end else if (start_ok_s) begin
            iter_nxt_s    = ITER_ZERO;
        end else begin
            iter_nxt_s    = iter_count_r;
        end
        if (start_ok_s) begin
            terr_nxt_s = 1'b0;
        end else if (state_nxt_s == ST_ERROR) begin
            terr_nxt_s = 1'b1;
        end else begin
            terr_nxt_s = terr_r;
        end
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            y_load_en_r  <= 1'b0;
            accum_en_r   <= 1'b0;
            vwrite_en_r  <= 1'b0;
            rd_bank_r    <= 1'b0;
            wr_bank_r    <= 1'b1;
            iter_count_r <= ITER_ZERO;
            busy_r       <= 1'b0;
            done_pulse_r <= 1'b0;
            terr_r       <= 1'b0;
        end else begin
            y_load_en_r  <= y_load_en_nxt_s;
            accum_en_r   <= accum_en_nxt_s;
            vwrite_en_r  <= vwrite_en_nxt_s;
            rd_bank_r    <= rd_bank_nxt_s;
            wr_bank_r    <= ~rd_bank_nxt_s;
            iter_count_r <= iter_nxt_s;
            busy_r       <= busy_nxt_s;
            done_pulse_r <= done_pulse_nxt_s;
            terr_r       <= terr_nxt_s;
        end
    end

    assign y_load_en      = y_load_en_r;
    assign accum_en       = accum_en_r;
    assign vwrite_en      = vwrite_en_r;
    assign vsram_rd_bank  = rd_bank_r;
    assign vsram_wr_bank  = wr_bank_r;
    assign iter_count     = iter_count_r;
    assign busy           = busy_r;
    assign all_iters_done = done_pulse_r;
    assign timeout_err    = terr_r;

endmodule

// File: tb/tb_jacobi_iter_sequencer.sv
// Scoreboard bench for jacobi_iter_sequencer: expected solve outcomes are queued at start, a monitor
// checks them on all_iters_done / timeout_err events. Honours JACOBI_CONV_EXIT_EN like the design.
module tb_jacobi_iter_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       y_load_done;
    logic       accum_done;
    logic       vwrite_done;
    logic       conv_flag;
    logic       y_load_en;
    logic       accum_en;
    logic       vwrite_en;
    logic       vsram_rd_bank;
    logic       vsram_wr_bank;
    logic [7:0] iter_count;
    logic       busy;
    logic       all_iters_done;
    logic       timeout_err;

    always #5 clock = ~clock;

    jacobi_iter_sequencer #(.NUM_ITERS(20), .ITER_W(8), .TIMEOUT_W(12)) dut (
        .clock(clock), .reset(reset), .start(start),
        .y_load_done(y_load_done), .accum_done(accum_done), .vwrite_done(vwrite_done),
        .conv_flag(conv_flag),
        .y_load_en(y_load_en), .accum_en(accum_en), .vwrite_en(vwrite_en),
        .vsram_rd_bank(vsram_rd_bank), .vsram_wr_bank(vsram_wr_bank),
        .iter_count(iter_count), .busy(busy), .all_iters_done(all_iters_done),
        .timeout_err(timeout_err)
    );

    // Engine models: done arrives delay_v cycles after the enable rises.
    int   delay_v = 3;
    int   withhold_iter = -1;
    logic extra_vw = 1'b0;
    logic conv_mode = 1'b0;
    int   y_cnt = 0;
    int   a_cnt = 0;
    int   w_cnt = 0;

    always @(negedge clock) begin
        y_cnt = y_load_en ? y_cnt + 1 : 0;
        a_cnt = accum_en  ? a_cnt + 1 : 0;
        w_cnt = vwrite_en ? w_cnt + 1 : 0;
    end

    assign y_load_done = y_load_en && (y_cnt == delay_v + 1);
    assign accum_done  = accum_en && (a_cnt == delay_v + 1) && (int'(iter_count) != withhold_iter);
    assign vwrite_done = (vwrite_en && (w_cnt == delay_v + 1)) || extra_vw;
    assign conv_flag   = conv_mode && (iter_count == 8'd6);

    typedef struct {
        int id;
        bit is_err;
        int iters;
        bit bank;
        int cycles;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests_run = 0;
    int   tests_failed = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    logic terr_prev = 1'b0;
    logic ev_err;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        tests_run++;
        if (act != req) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Monitor: every completion or error event consumes one expected record
    always @(negedge clock) begin
        ev_err = timeout_err && !terr_prev;
        if (all_iters_done || ev_err) begin
            if (exp_q.size() == 0) begin
                check("unexpected_event", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("ev%0d_kind", mon_e.id), int'(ev_err), int'(mon_e.is_err));
                check($sformatf("ev%0d_iters", mon_e.id), int'(iter_count), mon_e.iters);
                check($sformatf("ev%0d_bank", mon_e.id), int'(vsram_rd_bank), int'(mon_e.bank));
                check($sformatf("ev%0d_wrbank", mon_e.id), int'(vsram_wr_bank), int'(!mon_e.bank));
                check($sformatf("ev%0d_busy", mon_e.id), int'(busy), 0);
                check($sformatf("ev%0d_ens", mon_e.id), int'({y_load_en, accum_en, vwrite_en}), 0);
                check($sformatf("ev%0d_cycles", mon_e.id), cyc - start_cyc, mon_e.cycles);
            end
        end
        terr_prev = timeout_err;
    end

    task automatic push_exp(input int id, input bit is_err, input int iters, input bit bank, input int cycles);
        exp_t e;
        e.id = id; e.is_err = is_err; e.iters = iters; e.bank = bank; e.cycles = cycles;
        exp_q.push_back(e);
    endtask

    task automatic issue_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({name, "_no_event"}, 1, 0);
            exp_q.delete();
        end
        @(negedge clock);
    endtask

    task automatic wait_phase(input int which, input int it, input string name);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && n < 3000) begin
            @(negedge clock);
            n++;
            case (which)
                1:       hit = y_load_en && (int'(iter_count) == it);
                2:       hit = accum_en  && (int'(iter_count) == it);
                3:       hit = vwrite_en && (int'(iter_count) == it);
                default: hit = 1'b1;
            endcase
        end
        if (!hit) check({name, "_wait"}, 0, 1);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state
        check("rst_ens", int'({y_load_en, accum_en, vwrite_en}), 0);
        check("rst_rd_bank", int'(vsram_rd_bank), 0);
        check("rst_wr_bank", int'(vsram_wr_bank), 1);
        check("rst_iter", int'(iter_count), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(all_iters_done), 0);
        check("rst_terr", int'(timeout_err), 0);

        // 1: 3-cycle engine latency, 13 cycles per iteration
        delay_v = 3;
        push_exp(1, 1'b0, 20, 1'b0, 260);
        issue_start();
        check("t1_busy", int'(busy), 1);
        check("t1_y_en_entry", int'(y_load_en), 1);
        wait_drain("t1", 400);
        check("t1_pulse_once", int'(all_iters_done), 0);
        check("t1_iter_hold", int'(iter_count), 20);

        // 4: start while busy and a stray vwrite_done in LOAD_Y are both ignored
        push_exp(4, 1'b0, 20, 1'b0, 260);
        issue_start();
        wait_phase(2, 2, "t4_accum");
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t4_iter_after_start", int'(iter_count), 2);
        check("t4_still_accum", int'(accum_en), 1);
        wait_phase(1, 3, "t4_load");
        extra_vw = 1'b1;
        @(negedge clock);
        extra_vw = 1'b0;
        check("t4_still_load", int'(y_load_en), 1);
        wait_drain("t4", 400);

        // 2: zero-wait engines, 4 cycles per iteration
        delay_v = 0;
        push_exp(2, 1'b0, 20, 1'b0, 80);
        issue_start();
        wait_drain("t2", 200);

        // 3: accum_done withheld in iteration 5 -> watchdog error after 4095 cycles of ACCUM
        withhold_iter = 4;
        push_exp(3, 1'b1, 4, 1'b0, 4112);
        issue_start();
        wait_drain("t3", 5000);
        check("t3_terr_sticky", int'(timeout_err), 1);
        check("t3_busy", int'(busy), 0);
        withhold_iter = -1;
        push_exp(31, 1'b0, 20, 1'b0, 80);
        issue_start();
        check("t3_terr_cleared", int'(timeout_err), 0);
        check("t3_restart_iter", int'(iter_count), 0);
        wait_drain("t3r", 200);

        // 5: reset in WRITE_V of iteration 10
        delay_v = 3;
        issue_start();
        wait_phase(3, 9, "t5_wv");
        check("t5_bank_pre", int'(vsram_rd_bank), 1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check("t5_ens", int'({y_load_en, accum_en, vwrite_en}), 0);
        check("t5_iter", int'(iter_count), 0);
        check("t5_bank", int'(vsram_rd_bank), 0);
        check("t5_busy", int'(busy), 0);

        // 6: convergence at SWAP of iteration 7
        delay_v = 0;
        conv_mode = 1'b1;
`ifdef JACOBI_CONV_EXIT_EN
        push_exp(6, 1'b0, 7, 1'b1, 28);
`else
        push_exp(6, 1'b0, 20, 1'b0, 80);
`endif
        issue_start();
        wait_drain("t6", 200);
        conv_mode = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
